// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a
// slow line-wide memory. Hits complete combinationally; misses stall for write-back/refill.
`timescale 1ns/1ps
module dcache_controller #(
    parameter int SET_BITS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = 32 - 5 - SET_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_REFILL    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                gap_q, gap_d;
    logic [255:0]        refill_q, refill_d;

    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [255:0]        line_q [SETS];
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;

    logic                mem_enable_q, mem_enable_d;
    logic                mem_write_q, mem_write_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [255:0]        mem_data_q, mem_data_d;

    logic [SET_BITS-1:0] index_s;
    logic [TAG_W-1:0]    tag_s;
    logic [2:0]          word_s;
    logic [7:0]          line_bit_s;
    logic                hit_s;
    logic                victim_dirty_s;
    logic                store_hit_s;
    logic [31:0]         victim_addr_s;
    logic [31:0]         fetch_addr_s;
    logic                unused_s;

    assign index_s        = cpu_addr_i[4+SET_BITS:5];
    assign tag_s          = cpu_addr_i[31:5+SET_BITS];
    assign word_s         = cpu_addr_i[4:2];
    assign line_bit_s     = {word_s, 5'd0};
    assign unused_s       = &{1'b0, cpu_addr_i[1:0]};

    assign hit_s          = valid_q[index_s] & (tag_q[index_s] == tag_s);
    assign victim_dirty_s = valid_q[index_s] & dirty_q[index_s];
    assign store_hit_s    = (state_q == S_IDLE) & cpu_req_i & cpu_write_i & hit_s;
    assign victim_addr_s  = {tag_q[index_s], index_s, 5'd0};
    assign fetch_addr_s   = {tag_s, index_s, 5'd0};

    assign cpu_data_o     = line_q[index_s][line_bit_s +: 32];
    assign cpu_stall_o    = (state_q != S_IDLE) | (cpu_req_i & ~hit_s);

    assign mem_enable_o   = mem_enable_q;
    assign mem_write_o    = mem_write_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;

    // Next-state logic and the memory-side outputs for the state being entered.
    always_comb begin
        state_d      = state_q;
        gap_d        = 1'b0;
        refill_d     = refill_q;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = 32'd0;
        mem_data_d   = 256'd0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i && !hit_s) begin
                    if (victim_dirty_s) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = S_ALLOCATE;
                    gap_d   = 1'b1;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_ALLOCATE: begin
                // An ack during the post-write-back gap cannot belong to the fetch.
                if (mem_ack_i && !gap_q) begin
                    refill_d = mem_data_i;
                    state_d  = S_REFILL;
                end else begin
                    state_d  = S_ALLOCATE;
                end
            end
            S_REFILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_WRITEBACK: begin
                mem_enable_d = 1'b1;
                mem_write_d  = 1'b1;
                mem_addr_d   = victim_addr_s;
                mem_data_d   = line_q[index_s];
            end
            S_ALLOCATE: begin
                mem_enable_d = ~gap_d;
                mem_write_d  = 1'b0;
                mem_addr_d   = fetch_addr_s;
            end
            default: begin
                mem_enable_d = 1'b0;
            end
        endcase
    end

    // Control state, valid/dirty bits and registered memory-side outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            gap_q        <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_data_q   <= 256'd0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            if (state_q == S_REFILL) begin
                valid_q[index_s] <= 1'b1;
                dirty_q[index_s] <= 1'b0;
            end else if (store_hit_s) begin
                dirty_q[index_s] <= 1'b1;
            end
        end
    end

    // Tag/line storage and refill buffer; contents are undefined until validated.
    always_ff @(posedge clk_i) begin
        refill_q <= refill_d;
        if (!rst_i) begin
            if (state_q == S_REFILL) begin
                tag_q[index_s]  <= tag_s;
                line_q[index_s] <= refill_q;
            end else if (store_hit_s) begin
                line_q[index_s][line_bit_s +: 32] <= cpu_data_i;
            end
        end
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data-cache controller between the pipeline MEM stage and the off-chip data memory. It holds tag, valid, dirty and line storage. Hits are served in the same cycle. On a miss it stalls the pipeline and runs a write-back/refill sequence against a slow memory with a request/acknowledge handshake. The stall output freezes the pipeline registers, the same way the hazard unit's NoOP path does.

## Interface
- SET_BITS, 4, index width; number of sets = 2^SET_BITS (16).
- Line size is fixed at 32 bytes (256 bits, 8 words).
- Address split: offset = addr[4:0], word select = addr[4:2], index = addr[4+SET_BITS:5], tag = addr[31:5+SET_BITS] (23 bits at default).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cpu_req_i  in  1  access request (MemRead_o | MemWrite_o of the MEM stage).
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address, word aligned.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid when cpu_req_i & ~cpu_write_i & ~cpu_stall_o.
- cpu_stall_o  out  1  pipeline freeze.
- mem_enable_o  out  1  memory request, held until acknowledged.
- mem_write_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address, bits [4:0] = 0.
- mem_data_o  out  256  victim line for write-back.
- mem_data_i  in  256  fetched line; sampled in the mem_ack_i cycle.
- mem_ack_i  in  1  one-cycle completion pulse.

## Operation
- Hit: hit = valid[index] & (tag_array[index] == tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE, hit, load: cpu_data_o = the selected word, combinational. No state change.
- IDLE, hit, store: at the edge, the selected word is replaced with cpu_data_i and dirty[index] is set to 1.
- IDLE, miss, victim dirty: go to WRITEBACK.
- IDLE, miss, victim clean or invalid: go to ALLOCATE.
- WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line. On mem_ack_i go to ALLOCATE.
- ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}. On mem_ack_i, capture mem_data_i into a refill buffer and go to REFILL.
- REFILL: write the buffer into line[index], set tag, valid=1, dirty=0, then go to IDLE.
- Back in IDLE the request now hits and completes under the normal hit rules (a store sets dirty).
- cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit).
- mem_ack_i is ignored in IDLE and REFILL.
- Requester rule: cpu_addr_i, cpu_write_i and cpu_data_i stay stable while cpu_stall_o=1. The pipeline is frozen, so this holds.
- cpu_req_i=0 in IDLE: no state change, no array write, cpu_stall_o=0.

## Timing
Reset values (after a clock with rst_i=1):
- state IDLE.
- All valid and dirty bits 0.
- mem_enable_o=0, mem_write_o=0, mem_addr_o=0, cpu_stall_o=0 (with cpu_req_i=0).
- Tag and data arrays are not reset.

Reset during WRITEBACK, ALLOCATE or REFILL:
- Returns to IDLE; mem_enable_o drops in the next cycle.
- The partial transfer is abandoned and all lines are invalidated.
- A late mem_ack_i is ignored.

Latency, with the miss seen in cycle 0 and mem_ack_i arriving L cycles after mem_enable_o rises (L ≥ 1):
- Hit: 0 stall cycles.
- Clean miss: ALLOCATE spans cycles 1..L, REFILL is cycle L+1, the hit completes in cycle L+2. cpu_stall_o is high for cycles 0..L+1 (L+2 cycles).
- Dirty miss: the write-back adds L cycles, giving 2L+2 stall cycles.

Handshake:
- mem_enable_o is level, asserted from state entry through the ack cycle inclusive.
- It is deasserted for at least one cycle between WRITEBACK and ALLOCATE. ALLOCATE therefore raises it one cycle after the write-back ack; that gap cycle counts toward L for the fetch.

## Test plan
- Cold load: after reset, load 0x0000_0040 with L=10. Expect mem_addr_o=0x40, mem_write_o=0, cpu_stall_o high for exactly 12 cycles, then cpu_data_o = word 0 of the returned line.
- Hit: repeat load 0x44 immediately. Expect cpu_stall_o=0, cpu_data_o = word 1, mem_enable_o stays 0.
- Store hit: store 0xDEADBEEF to 0x48. Expect zero stall. A following load of 0x48 returns 0xDEADBEEF.
- Dirty conflict: load 0x240 (same index 2, tag 1). Expect a write-back to 0x40 with mem_data_o word 2 = 0xDEADBEEF. Then a fetch from 0x240 with mem_enable_o low for one cycle in between. Total stall 2L+2 = 22 cycles.
- Write-miss allocate: store to 0x1000_0000 on a clean miss. Expect a fetch and refill, then the word is updated and dirty is set (checked by a later conflict write-back).
- Reset during ALLOCATE: assert rst_i for 1 cycle while mem_enable_o=1. Expect mem_enable_o=0 next cycle and a stray mem_ack_i ignored. A re-load of 0x44 misses again.
